// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC sequencer.
// Alignment rules switch to 2-byte granularity when PC_SEQ_COMPRESSED_EN is defined.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        HALT      = 2'd2,
        WAIT_TRAP = 2'd3
    } pc_state_e;

    localparam int unsigned INC32 = 4;
    localparam int unsigned INC16 = 2;

`ifdef PC_SEQ_COMPRESSED_EN
    localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
    localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return |(lsb & ALIGN_MASK);
    endfunction

    // Clears whichever low bits the current alignment rule requires to be zero.
    function automatic logic [1:0] align_lsb(input logic [1:0] lsb);
        return lsb & ~ALIGN_MASK;
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC / next-state priority logic for pc_sequencer.
// Optional ilen16 input exists only when PC_SEQ_COMPRESSED_EN is defined.
module pc_next_calc
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  pc_state_e        state,
    input  logic [XLEN-1:0]  pc,
    input  logic             ready,
    input  logic             redirect,
    input  logic [XLEN-1:0]  target,
    input  logic             trap,
    input  logic [XLEN-1:0]  vector,
    input  logic             halt,
`ifdef PC_SEQ_COMPRESSED_EN
    input  logic             ilen16,
`endif
    output logic [XLEN-1:0]  next_pc,
    output pc_state_e        next_state,
    output logic             take_misalign
);

    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] step;
    logic            bad_target;

    always_comb begin
        trap_pc    = {vector[XLEN-1:2], align_lsb(vector[1:0])};
`ifdef PC_SEQ_COMPRESSED_EN
        step       = ilen16 ? XLEN'(INC16) : XLEN'(INC32);
`else
        step       = XLEN'(INC32);
`endif
        bad_target = is_misaligned(target[1:0]);

        next_pc       = pc;
        next_state    = state;
        take_misalign = 1'b0;

        // Trap always wins and bypasses the alignment check on the redirect target.
        case (state)
            BOOT: begin
                next_state = RUN;
                if (trap) next_pc = trap_pc;
            end
            RUN: begin
                if (trap) begin
                    next_pc = trap_pc;
                end else if (redirect) begin
                    if (bad_target) begin
                        take_misalign = 1'b1;
                        next_state    = WAIT_TRAP;
                    end else begin
                        next_pc = target;
                    end
                end else if (halt) begin
                    next_state = HALT;
                end else if (ready) begin
                    next_pc = pc + step;
                end
            end
            HALT: begin
                if (trap) begin
                    next_pc    = trap_pc;
                    next_state = RUN;
                end else if (redirect) begin
                    if (bad_target) begin
                        take_misalign = 1'b1;
                        next_state    = WAIT_TRAP;
                    end else begin
                        next_pc = target;
                    end
                end else if (!halt) begin
                    next_state = RUN;
                end
            end
            WAIT_TRAP: begin
                if (trap) begin
                    next_pc    = trap_pc;
                    next_state = RUN;
                end
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and control FSM; presents the PC to fetch over valid/ready.
// Define PC_SEQ_COMPRESSED_EN to add ilen16_i and 2-byte alignment rules.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             clr,
    output logic [XLEN-1:0]  pc_o,
    output logic             pc_valid_o,
    input  logic             pc_ready_i,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_i,
    input  logic [XLEN-1:0]  trap_vector_i,
    input  logic             halt_i,
`ifdef PC_SEQ_COMPRESSED_EN
    input  logic             ilen16_i,
`endif
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o,
    output logic [1:0]       state_o
);

    pc_state_e       state;
    pc_state_e       next_state;
    logic [XLEN-1:0] next_pc;
    logic            take_misalign;

    pc_next_calc #(.XLEN(XLEN)) u_next (
        .state         (state),
        .pc            (pc_o),
        .ready         (pc_ready_i),
        .redirect      (redirect_i),
        .target        (redirect_target_i),
        .trap          (trap_i),
        .vector        (trap_vector_i),
        .halt          (halt_i),
`ifdef PC_SEQ_COMPRESSED_EN
        .ilen16        (ilen16_i),
`endif
        .next_pc       (next_pc),
        .next_state    (next_state),
        .take_misalign (take_misalign)
    );

    // Valid is registered from the next state so it lines up with the FSM.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state           <= BOOT;
            pc_o            <= RESET_VECTOR;
            pc_valid_o      <= 1'b0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            state      <= next_state;
            pc_o       <= next_pc;
            pc_valid_o <= (next_state == RUN);
            misalign_o <= take_misalign;
            if (take_misalign) misalign_addr_o <= redirect_target_i;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expectations queued with each stimulus cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        halt = 1'b0;
`ifdef PC_SEQ_COMPRESSED_EN
    logic        ilen16 = 1'b0;
`endif
    logic        misalign;
    logic [31:0] misalign_addr;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic [1:0]  st;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk               (clk),
        .clr               (clr),
        .pc_o              (pc),
        .pc_valid_o        (pc_valid),
        .pc_ready_i        (pc_ready),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .trap_i            (trap),
        .trap_vector_i     (trap_vector),
        .halt_i            (halt),
`ifdef PC_SEQ_COMPRESSED_EN
        .ilen16_i          (ilen16),
`endif
        .misalign_o        (misalign),
        .misalign_addr_o   (misalign_addr),
        .state_o           (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input exp_t e);
        check_eq({e.tag, ".pc"},    pc,                    e.pc);
        check_eq({e.tag, ".valid"}, {31'd0, pc_valid},     {31'd0, e.valid});
        check_eq({e.tag, ".state"}, {30'd0, state},        {30'd0, e.st});
        check_eq({e.tag, ".mis"},   {31'd0, misalign},     {31'd0, e.mis});
        check_eq({e.tag, ".maddr"}, misalign_addr,         e.maddr);
    endtask

    // Push the expectation for the coming edge, clock it, then pop and compare.
    // Redirect and trap are single-cycle pulses and are cleared after the edge.
    task automatic cyc(input string tag, input logic [31:0] epc, input logic ev,
                       input logic [1:0] est, input logic emis, input logic [31:0] emaddr);
        exp_t e;
        e.tag = tag; e.pc = epc; e.valid = ev; e.st = est; e.mis = emis; e.maddr = emaddr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        trap     = 1'b0;
        if (sb.size() == 0) begin
            check_eq({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            check_all(sb.pop_front());
        end
    endtask

    initial begin
        exp_t r;
        // Asynchronous reset state, before any clock edge
        #2;
        r.tag = "reset"; r.pc = 32'h0; r.valid = 1'b0; r.st = 2'd0; r.mis = 1'b0; r.maddr = 32'h0;
        check_all(r);
        @(negedge clk);
        clr = 1'b1;
        pc_ready = 1'b1;
        r.tag = "boot"; check_all(r);

        cyc("run0", 32'h0,  1, 1, 0, 0);
        cyc("inc4", 32'h4,  1, 1, 0, 0);
        cyc("inc8", 32'h8,  1, 1, 0, 0);
        cyc("incc", 32'hC,  1, 1, 0, 0);
        cyc("inc10", 32'h10, 1, 1, 0, 0);

        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("stall", 32'h10, 1, 1, 0, 0);
        pc_ready = 1'b1;
        cyc("resume", 32'h14, 1, 1, 0, 0);

        pc_ready = 1'b0;
        redirect = 1'b1; redirect_target = 32'h200;
        cyc("redir200", 32'h200, 1, 1, 0, 0);
        redirect = 1'b1; redirect_target = 32'h202;
        cyc("mis202", 32'h200, 0, 3, 1, 32'h202);
        redirect = 1'b1; redirect_target = 32'h300; halt = 1'b1; pc_ready = 1'b1;
        cyc("waitign", 32'h200, 0, 3, 0, 32'h202);
        halt = 1'b0; pc_ready = 1'b0;

        trap = 1'b1; trap_vector = 32'h8000_0003;
        cyc("trapvec", 32'h8000_0000, 1, 1, 0, 32'h202);
        trap = 1'b1; trap_vector = 32'h100; redirect = 1'b1; redirect_target = 32'h302;
        cyc("trapwin", 32'h100, 1, 1, 0, 32'h202);

        redirect = 1'b1; redirect_target = 32'h40;
        cyc("redir40", 32'h40, 1, 1, 0, 32'h202);
        halt = 1'b1; pc_ready = 1'b1;
        cyc("halt", 32'h40, 0, 2, 0, 32'h202);
        cyc("halthold", 32'h40, 0, 2, 0, 32'h202);
        halt = 1'b0;
        cyc("unhalt", 32'h40, 1, 1, 0, 32'h202);
        cyc("adv44", 32'h44, 1, 1, 0, 32'h202);
        halt = 1'b1;
        cyc("halt2", 32'h44, 0, 2, 0, 32'h202);
        redirect = 1'b1; redirect_target = 32'h80;
        cyc("haltredir", 32'h80, 0, 2, 0, 32'h202);
        halt = 1'b0; pc_ready = 1'b0;
        cyc("unhalt2", 32'h80, 1, 1, 0, 32'h202);

        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cyc("redirtop", 32'hFFFF_FFFC, 1, 1, 0, 32'h202);
        pc_ready = 1'b1;
        cyc("wrap", 32'h0, 1, 1, 0, 32'h202);
        cyc("postwrap", 32'h4, 1, 1, 0, 32'h202);

        // Mid-cycle reset: outputs must clear without a clock edge
        #2;
        clr = 1'b0;
        #1;
        r.tag = "midclr"; r.pc = 32'h0; r.valid = 1'b0; r.st = 2'd0; r.mis = 1'b0; r.maddr = 32'h0;
        check_all(r);
        @(negedge clk);
        clr = 1'b1;
        trap = 1'b1; trap_vector = 32'h123;
        cyc("boottrap", 32'h120, 1, 1, 0, 0);

`ifdef PC_SEQ_COMPRESSED_EN
        pc_ready = 1'b0;
        redirect = 1'b1; redirect_target = 32'h10;
        cyc("c_redir10", 32'h10, 1, 1, 0, 0);
        pc_ready = 1'b1; ilen16 = 1'b1;
        cyc("c_inc2", 32'h12, 1, 1, 0, 0);
        ilen16 = 1'b0; pc_ready = 1'b0;
        redirect = 1'b1; redirect_target = 32'h202;
        cyc("c_redir202", 32'h202, 1, 1, 0, 0);
        redirect = 1'b1; redirect_target = 32'h203;
        cyc("c_mis203", 32'h202, 0, 3, 1, 32'h203);
        trap = 1'b1; trap_vector = 32'h8000_0003;
        cyc("c_trap", 32'h8000_0002, 1, 1, 0, 32'h203);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
